paketleme_param: RTL

- Parametrised successor of the single-box packaging controller.
- Fills `kutu_hedefi` boxes, each of runtime capacity `kapasite`, with phones that pass inspection, and counts phones that are rejected.
- Optionally applies a multi-cycle banderole to each closed box and accumulates a saturating packaging cost.
- Sits between the inspection stage (valid/result stream) and the shipping stage, which consumes `bitti`.

---
 rtl/paketleme_param.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/paketleme_param.sv
// ---------------------------------------------------------------------------
// paketleme_param
//
// Packaging controller between the inspection stage and the shipping stage.
// Fills a runtime number of boxes (kutu_hedefi), each holding a runtime number
// of phones (kapasite). Phones that fail inspection are counted as rejects.
// Each closed box may optionally get a banderole that takes BANDROL_CYC
// cycles. Every closed box adds a fixed cost, plus an extra cost when a
// banderole is applied; the cost accumulator saturates.
//
// Handshake: a phone is taken on a rising edge where kontrol_gecerli=1 and
// hazir=1. hazir is a pure state decode (1 only while filling); phones
// offered while hazir=0 are dropped and never counted. There is no
// back-pressure on the inspection stage.
//
// Ports:
//   saat            in   clock, rising edge
//   reset           in   asynchronous, active-low reset
//   basla           in   start level (must drop after a job before restart)
//   kontrol_gecerli in   a phone is presented this cycle
//   kontrol_sonucu  in   1 = pass, 0 = reject
//   kapasite        in   [W]  phones per box, latched at start
//   kutu_hedefi     in   [K]  boxes per job, latched at start
//   bandrol         in   apply banderole to each box, latched at start
//   hazir           out  block accepts a phone this cycle
//   bitti           out  job complete
//   telefon_sayisi  out  [W]  phones in the current box
//   reddedilen      out  [W]  rejected phones this job (saturating)
//   kutu_sayisi     out  [K]  boxes completed this job
//   maliyet         out  [C]  accumulated cost (saturating)
//
// The FSM state is held in r_durum (type durum_t) for observation.
// ---------------------------------------------------------------------------
module paketleme_param #(
    parameter int W               = 10,
    parameter int K               = 4,
    parameter int C               = 8,
    parameter int BANDROL_CYC     = 3,
    parameter int TEMEL_MALIYET   = 2,
    parameter int BANDROL_MALIYET = 1
) (
    input  logic         saat,
    input  logic         reset,
    input  logic         basla,
    input  logic         kontrol_gecerli,
    input  logic         kontrol_sonucu,
    input  logic [W-1:0] kapasite,
    input  logic [K-1:0] kutu_hedefi,
    input  logic         bandrol,
    output logic         hazir,
    output logic         bitti,
    output logic [W-1:0] telefon_sayisi,
    output logic [W-1:0] reddedilen,
    output logic [K-1:0] kutu_sayisi,
    output logic [C-1:0] maliyet
);

    typedef enum logic [2:0] {
        BOSTA   = 3'd0,
        DOLUM   = 3'd1,
        KAPAT   = 3'd2,
        BANDROL = 3'd3,
        BITTI   = 3'd4
    } durum_t;

    // Banderole cycle counter runs 0 .. BANDROL_CYC-1.
    localparam int BW = (BANDROL_CYC > 1) ? $clog2(BANDROL_CYC) : 1;
    localparam logic [BW-1:0] BANDROL_SON = BW'(BANDROL_CYC - 1);

    // Cost is summed one bit wider than the accumulator so overflow is
    // visible in the top bit and can be clamped.
    localparam int CW = C + 1;
    localparam logic [CW-1:0] ARTIS_TEMEL = CW'(TEMEL_MALIYET);
    localparam logic [CW-1:0] ARTIS_BAND  = CW'(TEMEL_MALIYET + BANDROL_MALIYET);

    durum_t         r_durum;
    logic [W-1:0]   r_kap;
    logic [K-1:0]   r_hedef;
    logic           r_bandrol;
    logic [W-1:0]   r_tel;
    logic [W-1:0]   r_red;
    logic [K-1:0]   r_kutu;
    logic [C-1:0]   r_maliyet;
    logic [BW-1:0]  r_bcnt;

    durum_t         w_durum_n;
    logic [W-1:0]   w_kap_n;
    logic [K-1:0]   w_hedef_n;
    logic           w_bandrol_n;
    logic [W-1:0]   w_tel_n;
    logic [W-1:0]   w_red_n;
    logic [K-1:0]   w_kutu_n;
    logic [C-1:0]   w_maliyet_n;
    logic [BW-1:0]  w_bcnt_n;

    logic           w_commit;
    logic [W-1:0]   w_tel_inc;
    logic [K-1:0]   w_kutu_inc;
    logic [CW-1:0]  w_maliyet_toplam;
    logic [C-1:0]   w_maliyet_sat;

    assign w_tel_inc        = r_tel + W'(1);
    assign w_kutu_inc       = r_kutu + K'(1);
    assign w_maliyet_toplam = {1'b0, r_maliyet} + (r_bandrol ? ARTIS_BAND : ARTIS_TEMEL);
    assign w_maliyet_sat    = w_maliyet_toplam[C] ? {C{1'b1}} : w_maliyet_toplam[C-1:0];

    // Next-state and datapath decode.
    always_comb begin
        w_durum_n   = r_durum;
        w_kap_n     = r_kap;
        w_hedef_n   = r_hedef;
        w_bandrol_n = r_bandrol;
        w_tel_n     = r_tel;
        w_red_n     = r_red;
        w_kutu_n    = r_kutu;
        w_maliyet_n = r_maliyet;
        w_bcnt_n    = r_bcnt;
        w_commit    = 1'b0;

        case (r_durum)
            BOSTA: begin
                // Counters hold here until a new start clears them.
                if (basla) begin
                    w_kap_n     = kapasite;
                    w_hedef_n   = kutu_hedefi;
                    w_bandrol_n = bandrol;
                    w_tel_n     = '0;
                    w_red_n     = '0;
                    w_kutu_n    = '0;
                    w_maliyet_n = '0;
                    w_bcnt_n    = '0;
                    // An empty job completes at once.
                    if ((kapasite == '0) || (kutu_hedefi == '0)) begin
                        w_durum_n = BITTI;
                    end else begin
                        w_durum_n = DOLUM;
                    end
                end
            end
            DOLUM: begin
                if (kontrol_gecerli) begin
                    if (kontrol_sonucu) begin
                        w_tel_n = w_tel_inc;
                        if (w_tel_inc == r_kap) begin
                            w_durum_n = KAPAT;
                        end
                    end else if (r_red != {W{1'b1}}) begin
                        w_red_n = r_red + W'(1);
                    end
                end
            end
            KAPAT: begin
                if (r_bandrol) begin
                    w_durum_n = BANDROL;
                    w_bcnt_n  = '0;
                end else begin
                    w_commit = 1'b1;
                end
            end
            BANDROL: begin
                if (r_bcnt == BANDROL_SON) begin
                    w_commit = 1'b1;
                end else begin
                    w_bcnt_n = r_bcnt + BW'(1);
                end
            end
            BITTI: begin
                // A held start level does not re-trigger a job.
                if (!basla) begin
                    w_durum_n = BOSTA;
                end
            end
            default: begin
                w_durum_n = BOSTA;
            end
        endcase

        // Box commit: shared by the plain close and the banderole path.
        if (w_commit) begin
            w_kutu_n    = w_kutu_inc;
            w_maliyet_n = w_maliyet_sat;
            if (w_kutu_inc == r_hedef) begin
                w_durum_n = BITTI;   // last box stays visible as full
            end else begin
                w_tel_n   = '0;
                w_durum_n = DOLUM;
            end
        end
    end

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            r_durum   <= BOSTA;
            r_kap     <= '0;
            r_hedef   <= '0;
            r_bandrol <= 1'b0;
            r_tel     <= '0;
            r_red     <= '0;
            r_kutu    <= '0;
            r_maliyet <= '0;
            r_bcnt    <= '0;
        end else begin
            r_durum   <= w_durum_n;
            r_kap     <= w_kap_n;
            r_hedef   <= w_hedef_n;
            r_bandrol <= w_bandrol_n;
            r_tel     <= w_tel_n;
            r_red     <= w_red_n;
            r_kutu    <= w_kutu_n;
            r_maliyet <= w_maliyet_n;
            r_bcnt    <= w_bcnt_n;
        end
    end

    assign hazir          = (r_durum == DOLUM);
    assign bitti          = (r_durum == BITTI);
    assign telefon_sayisi = r_tel;
    assign reddedilen     = r_red;
    assign kutu_sayisi    = r_kutu;
    assign maliyet        = r_maliyet;

endmodule
